// File: rtl/fft_frame_loader.sv
// fft_frame_loader: collects a continuous sample stream into 256-sample frames
// held in a two-bank ping-pong buffer, then streams each complete frame into
// the FFT load port when the FFT is idle.
// Write and read sides run independently. The bank_full flags hand a bank from
// the writer to the reader, and back again once the reader has drained it.
module fft_frame_loader #(
  parameter int DATA_W = 17,
  parameter int N      = 256,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              fft_busy,
  input  logic              fft_full_n,
  output logic [DATA_W-1:0] time_dout,
  output logic              ld_n,
  output logic              frame_sent,
  output logic [15:0]       frame_cnt
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_PTR = AW'(N - 1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  // Ping-pong sample storage, addressed as {bank, pointer}
  logic [DATA_W-1:0] mem [0:2*N-1];

  state_t            state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              rd_bank_q, rd_bank_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              ld_n_q;
  logic [DATA_W-1:0] time_dout_q;
  logic              frame_sent_q;
  logic [15:0]       frame_cnt_q;

  logic              wr_en_s;
  logic              rd_en_s;
  logic              frame_done_s;
  logic [1:0]        set_full_s;
  logic [1:0]        clr_full_s;
  logic [AW:0]       wr_addr_s;
  logic [AW:0]       rd_addr_s;

  // The writer may fill its current bank unless the reader still owns it
  assign s_ready   = ~rst & ~bank_full_q[wr_bank_q];
  assign wr_en_s   = s_valid & s_ready;
  assign wr_addr_s = {wr_bank_q, wr_ptr_q};
  assign rd_addr_s = {rd_bank_q, rd_ptr_q};

  assign time_dout  = time_dout_q;
  assign ld_n       = ld_n_q;
  assign frame_sent = frame_sent_q;
  assign frame_cnt  = frame_cnt_q;

  // Write-side pointer advance and bank hand-over on the last sample of a frame
  always_comb begin
    wr_bank_d  = wr_bank_q;
    wr_ptr_d   = wr_ptr_q;
    set_full_s = 2'b00;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + ONE_PTR;
      if (wr_ptr_q == LAST_PTR) begin
        set_full_s[wr_bank_q] = 1'b1;
        wr_bank_d             = ~wr_bank_q;
      end else begin
        wr_bank_d = wr_bank_q;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Read FSM: wait for a full bank and an idle FFT, then issue one read per non-stalled cycle
  always_comb begin
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    rd_ptr_d     = rd_ptr_q;
    rd_en_s      = 1'b0;
    frame_done_s = 1'b0;
    clr_full_s   = 2'b00;
    case (state_q)
      IDLE: begin
        if (bank_full_q[rd_bank_q] & ~fft_busy) begin
          state_d  = STREAM;
          rd_ptr_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (fft_full_n) begin
          rd_en_s  = 1'b1;
          rd_ptr_d = rd_ptr_q + ONE_PTR;
          if (rd_ptr_q == LAST_PTR) begin
            clr_full_s[rd_bank_q] = 1'b1;
            rd_bank_d             = ~rd_bank_q;
            frame_done_s          = 1'b1;
            state_d               = IDLE;
          end else begin
            state_d = STREAM;
          end
        end else begin
          rd_ptr_d = rd_ptr_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Writer sets and reader clears always target different banks, so both apply together
  assign bank_full_d = (bank_full_q | set_full_s) & ~clr_full_s;

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_bank_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_ptr_q    <= '0;
      bank_full_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_bank_q   <= rd_bank_d;
      rd_ptr_q    <= rd_ptr_d;
      bank_full_q <= bank_full_d;
    end
  end

  // Sample buffer write port; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_addr_s] <= s_data;
    end
  end

  // Registered FFT load interface and frame accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_n_q       <= 1'b1;
      time_dout_q  <= '0;
      frame_sent_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
    end else begin
      ld_n_q       <= ~rd_en_s;
      frame_sent_q <= frame_done_s;
      if (rd_en_s) begin
        time_dout_q <= mem[rd_addr_s];
      end
      if (frame_done_s) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

endmodule
